// File: rtl/rotary_pkg.sv
// Shared constants and helpers for the rotary encoder event hub.
package rotary_pkg;

    localparam int unsigned ACC_W_DEF = 4;
    localparam int          ACC_MAX   = (2 ** (ACC_W_DEF - 1)) - 1;
    localparam int          ACC_MIN   = -ACC_MAX;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    // Signed step contributed by one encoder pulse: +1, -1 or 0.
    function automatic logic signed [1:0] step_of(input logic cnt, input logic cw);
        if (!cnt) begin
            return 2'sd0;
        end
        return (cw == DIR_CW) ? 2'sd1 : -2'sd1;
    endfunction

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/enc_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module enc_rr_arbiter
    import rotary_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned CH_W = clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] gnt_oh_c,
    output logic [CH_W-1:0] gnt_idx_c,
    output logic            any_req_c
);

    int unsigned     pos;
    logic [CH_W-1:0] pos_idx;

    always_comb begin
        gnt_oh_c  = '0;
        gnt_idx_c = '0;
        any_req_c = 1'b0;
        pos       = 0;
        pos_idx   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= N_CH) begin
                pos = pos - N_CH;
            end
            pos_idx = CH_W'(pos);
            if (!any_req_c && req[pos_idx]) begin
                any_req_c         = 1'b1;
                gnt_idx_c         = pos_idx;
                gnt_oh_c[pos_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rotary_event_hub.sv
// Merges per-encoder rotation pulses into saturating accumulators drained
// through a single round-robin arbitrated valid/ready event slot.
module rotary_event_hub
    import rotary_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_CH-1:0]        i_cnt,
    input  logic [N_CH-1:0]        i_cnt_cw,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [clog2(N_CH)-1:0] o_ch,
    output logic [ACC_W-1:0]       o_delta,
    output logic [N_CH-1:0]        o_ovf,
    input  logic [N_CH-1:0]        i_ovf_clr
);

    localparam int unsigned CH_W  = clog2(N_CH);
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] LIM = SUM_W'((2 ** (ACC_W - 1)) - 1);

    logic signed [ACC_W-1:0] acc_q [N_CH];
    logic signed [ACC_W-1:0] acc_d [N_CH];
    logic [CH_W-1:0]         ptr_q;
    logic [CH_W-1:0]         ptr_d;
    logic                    valid_d;
    logic [CH_W-1:0]         ch_d;
    logic [ACC_W-1:0]        delta_d;
    logic [N_CH-1:0]         ovf_d;

    logic [N_CH-1:0]         req;
    logic [N_CH-1:0]         gnt_oh;
    logic [CH_W-1:0]         gnt_idx;
    logic                    any_req;
    logic                    free;
    logic                    grant;
    logic [N_CH-1:0]         sat;
    logic signed [1:0]       st;
    logic signed [SUM_W-1:0] sum;

    always_comb begin
        for (int unsigned k = 0; k < N_CH; k++) begin
            req[k] = (acc_q[k] != '0);
        end
    end

    enc_rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .gnt_oh_c  (gnt_oh),
        .gnt_idx_c (gnt_idx),
        .any_req_c (any_req)
    );

    // Next-state: accumulate/saturate, drain the granted channel, load the slot.
    always_comb begin
        acc_d   = acc_q;
        ptr_d   = ptr_q;
        valid_d = o_valid;
        ch_d    = o_ch;
        delta_d = o_delta;
        sat     = '0;
        st      = '0;
        sum     = '0;
        free    = !o_valid || i_ready;
        grant   = free && any_req;

        for (int unsigned k = 0; k < N_CH; k++) begin
            st = step_of(i_cnt[k], i_cnt_cw[k]);
            if (grant && gnt_oh[k]) begin
                // Restart from this cycle's step so a coincident pulse is kept.
                acc_d[k] = ACC_W'(st);
            end else begin
                sum = SUM_W'(acc_q[k]) + SUM_W'(st);
                if (sum > LIM || sum < -LIM) begin
                    sat[k] = 1'b1;
                end else begin
                    acc_d[k] = ACC_W'(sum);
                end
            end
        end

        if (grant) begin
            valid_d = 1'b1;
            ch_d    = gnt_idx;
            delta_d = acc_q[gnt_idx];
            ptr_d   = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (free) begin
            valid_d = 1'b0;
        end

        ovf_d = (o_ovf & ~i_ovf_clr) | sat;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                acc_q[k] <= '0;
            end
            ptr_q   <= '0;
            o_valid <= 1'b0;
            o_ch    <= '0;
            o_delta <= '0;
            o_ovf   <= '0;
        end else begin
            acc_q   <= acc_d;
            ptr_q   <= ptr_d;
            o_valid <= valid_d;
            o_ch    <= ch_d;
            o_delta <= delta_d;
            o_ovf   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_rotary_event_hub.sv
// Directed and randomized checks of rotary_event_hub against an event-level model.
module tb_rotary_event_hub;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int LIM = 7;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic [N-1:0] i_cnt;
    logic [N-1:0] i_cnt_cw;
    logic         o_valid;
    logic         i_ready;
    logic [1:0]   o_ch;
    logic [W-1:0] o_delta;
    logic [N-1:0] o_ovf;
    logic [N-1:0] i_ovf_clr;

    int passed = 0;
    int total  = 0;

    int           m_acc [N];
    int           m_valid, m_ch, m_delta, m_ptr;
    logic [N-1:0] m_ovf;

    rotary_event_hub #(.N_CH(N), .ACC_W(W)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_cnt     (i_cnt),
        .i_cnt_cw  (i_cnt_cw),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_ch      (o_ch),
        .o_delta   (o_delta),
        .o_ovf     (o_ovf),
        .i_ovf_clr (i_ovf_clr)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_acc[k] = 0;
        m_valid = 0; m_ch = 0; m_delta = 0; m_ptr = 0; m_ovf = '0;
    endtask

    // One clock of the hub's rules, applied to the inputs seen at this edge.
    task automatic model_step();
        int g, s, t;
        bit free, granted;
        logic [N-1:0] sat;
        if (!i_rst_n) begin
            model_reset();
            return;
        end
        free = (m_valid == 0) || i_ready;
        g = -1;
        for (int i = 0; i < N; i++) begin
            if (g < 0 && m_acc[(m_ptr + i) % N] != 0) g = (m_ptr + i) % N;
        end
        granted = free && (g >= 0);
        if (granted) begin
            m_valid = 1; m_ch = g; m_delta = m_acc[g]; m_ptr = (g + 1) % N;
        end else if (free) begin
            m_valid = 0;
        end
        sat = '0;
        for (int k = 0; k < N; k++) begin
            s = i_cnt[k] ? (i_cnt_cw[k] ? 1 : -1) : 0;
            if (granted && k == g) begin
                m_acc[k] = s;
            end else begin
                t = m_acc[k] + s;
                if (t > LIM || t < -LIM) sat[k] = 1'b1;
                else m_acc[k] = t;
            end
        end
        m_ovf = (m_ovf & ~i_ovf_clr) | sat;
    endtask

    task automatic check_model();
        chk("valid", o_valid, m_valid);
        chk("ch", o_ch, m_ch);
        chk("delta", $signed(o_delta), m_delta);
        chk("ovf", o_ovf, m_ovf);
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic drive(input logic [N-1:0] c, input logic [N-1:0] d, input logic r);
        i_cnt = c; i_cnt_cw = d; i_ready = r;
        tick();
    endtask

    int exp_ch;

    initial begin
        i_rst_n = 1'b0; i_cnt = '0; i_cnt_cw = '0; i_ready = 1'b0; i_ovf_clr = '0;
        model_reset();
        #1;
        check_model();
        @(negedge i_clk); i_rst_n = 1'b1;

        // Traffic, then an asynchronous reset mid-stream.
        for (int i = 0; i < 6; i++) drive(4'($urandom), 4'($urandom), 1'b0);
        #2; i_rst_n = 1'b0; #1;
        model_reset();
        check_model();
        drive(4'b1111, 4'b1111, 1'b1);
        @(negedge i_clk); i_rst_n = 1'b1;
        drive('0, '0, 1'b1);
        chk("rst_valid", o_valid, 0);
        chk("rst_delta", $signed(o_delta), 0);

        // Single CW pulse on ch2: event two edges later, then slot empties.
        drive(4'b0100, 4'b0100, 1'b1);
        chk("t1_pre", o_valid, 0);
        drive('0, '0, 1'b1);
        chk("t1_valid", o_valid, 1);
        chk("t1_ch", o_ch, 2);
        chk("t1_delta", $signed(o_delta), 1);
        drive('0, '0, 1'b1);
        chk("t1_drop", o_valid, 0);

        // Stall: 3 CW then 1 CCW on ch0.
        drive(4'b0001, 4'b0001, 1'b0);
        drive(4'b0001, 4'b0001, 1'b0);
        drive(4'b0001, 4'b0001, 1'b0);
        drive(4'b0001, 4'b0000, 1'b0);
        chk("t2_held", $signed(o_delta), 1);
        drive('0, '0, 1'b1);
        chk("t2_ch", o_ch, 0);
        chk("t2_delta", $signed(o_delta), 1);
        drive('0, '0, 1'b1);

        // Saturation on ch1 and sticky flag clear.
        for (int i = 0; i < 10; i++) drive(4'b0010, 4'b0000, 1'b0);
        chk("t3_ovf", o_ovf[1], 1);
        drive('0, '0, 1'b1);
        chk("t3_ch", o_ch, 1);
        chk("t3_delta", $signed(o_delta), -7);
        i_ovf_clr = 4'b0010;
        drive('0, '0, 1'b1);
        i_ovf_clr = '0;
        chk("t3_clr", o_ovf[1], 0);

        // Fairness with every channel pulsing each cycle.
        exp_ch = m_ptr;
        for (int i = 0; i < 12; i++) begin
            drive(4'b1111, 4'b1111, 1'b1);
            if (m_valid != 0) begin
                chk("t4_rr", o_ch, exp_ch);
                exp_ch = (exp_ch + 1) % N;
            end
        end
        for (int i = 0; i < 6; i++) drive('0, '0, 1'b1);
        chk("t4_drain", o_valid, 0);

        // Coincident pulse on the grant cycle of ch3.
        drive(4'b0001, 4'b0001, 1'b0);
        drive('0, '0, 1'b0);
        drive(4'b1000, 4'b1000, 1'b0);
        drive(4'b1000, 4'b1000, 1'b0);
        drive(4'b1000, 4'b1000, 1'b1);
        chk("t5_ch", o_ch, 3);
        chk("t5_delta", $signed(o_delta), 2);
        drive('0, '0, 1'b1);
        chk("t5_next", $signed(o_delta), 1);
        drive('0, '0, 1'b1);

        // Net-zero rotation on ch1 while ch0 occupies the slot.
        drive(4'b0001, 4'b0001, 1'b0);
        drive('0, '0, 1'b0);
        drive(4'b0010, 4'b0010, 1'b0);
        drive(4'b0010, 4'b0000, 1'b0);
        drive('0, '0, 1'b0);
        chk("t6_hold", o_ch, 0);
        drive('0, '0, 1'b1);
        chk("t6_none", o_valid, 0);
        chk("t6_acc1", dut.acc_q[1], 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            i_ovf_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '0;
            drive(4'($urandom), 4'($urandom), 1'($urandom));
            if (m_valid != 0) chk("nonzero", (o_delta != '0), 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
